sram_word_ctrl: RTL and testbench

//  Sequences one 32-bit MEM-stage load/store as two 16-bit external SRAM cycles (low half, then high half).

---
 rtl/sram_word_ctrl_pkg.sv | 22 ++
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_word_ctrl.sv | 95 +++++++++
 tb/tb_sram_word_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_word_ctrl_pkg.sv
// Shared types and widths for the 32-bit-over-16-bit SRAM word controller.
package sram_word_ctrl_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned SRAM_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half hold counter: counts enabled cycles and flags the last one.
module sram_wait_counter
   import sram_word_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CW = cnt_width(WAIT_CYCLES);

   logic [CW-1:0] wait_cnt;

   assign tc_c = (wait_cnt == CW'(WAIT_CYCLES - 1));

   // Wraps to zero on terminal count so the next half starts fresh.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (clear || tc_c) begin
         wait_cnt <= '0;
      end else if (en) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sram_word_ctrl.sv
// Splits one 32-bit MEM-stage load/store into low/high 16-bit SRAM cycles,
// stalling the pipeline via sram_not_ready until the word is complete.
module sram_word_ctrl
   import sram_word_ctrl_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_r_en,
   input  logic                mem_w_en,
   input  logic [WORD_W-1:0]   addr,
   input  logic [WORD_W-1:0]   wdata,
   output logic [WORD_W-1:0]   rdata,
   output logic                sram_not_ready,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic                sram_we_n,
   output logic                sram_oe_n,
   inout  wire  [SRAM_DW-1:0]  sram_data
);

   state_t               state;
   logic                 op;
   logic [SRAM_AW-2:0]   widx;
   logic [WORD_W-1:0]    wdata_q;
   logic                 req;
   logic                 active;
   logic                 tc_c;
   logic                 drive;

   assign req            = mem_r_en | mem_w_en;
   assign active         = (state == ST_LO) || (state == ST_HI);
   assign sram_not_ready = req && (state != ST_DONE);

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait (
      .clk   (clk),
      .rst   (rst),
      .clear (!active || !req),
      .en    (active),
      .tc_c  (tc_c)
   );

   // Pins decode from registered state/op only, so reset releases them at once.
   assign sram_oe_n = !(active && (op == OP_RD));
   assign sram_we_n = !(active && (op == OP_WR));
   assign sram_addr = {widx, (state == ST_HI)};
   assign drive     = active && (op == OP_WR);
   assign sram_data = drive ? ((state == ST_HI) ? wdata_q[WORD_W-1:SRAM_DW]
                                                : wdata_q[SRAM_DW-1:0])
                            : {SRAM_DW{1'bz}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         op      <= OP_RD;
         widx    <= '0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state   <= ST_LO;
                  op      <= mem_w_en ? OP_WR : OP_RD;
                  widx    <= (SRAM_AW-1)'((addr - WORD_W'(BASE_ADDR)) >> 2);
                  wdata_q <= wdata;
               end
            end
            ST_LO: begin
               if (!req) begin
                  state <= ST_IDLE;
               end else if (tc_c) begin
                  state <= ST_HI;
                  if (op == OP_RD) rdata[SRAM_DW-1:0] <= sram_data;
               end
            end
            ST_HI: begin
               if (!req) begin
                  state <= ST_IDLE;
               end else if (tc_c) begin
                  state <= ST_DONE;
                  if (op == OP_RD) rdata[WORD_W-1:SRAM_DW] <= sram_data;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench for sram_word_ctrl: one instance with single-cycle halves,
// one with three-cycle halves, each with its own SRAM model.
module tb_sram_word_ctrl;

   localparam int unsigned WA = 1;
   localparam int unsigned WB = 3;

   typedef struct packed {
      logic [17:0] a;
      logic [15:0] d;
   } pin_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A (W=1), read/write SRAM model
   logic        r_a = 1'b0, w_a = 1'b0;
   logic [31:0] addr_a = '0, wdata_a = '0;
   logic [31:0] rdata_a;
   logic        nr_a, we_n_a, oe_n_a;
   logic [17:0] saddr_a;
   wire  [15:0] sdata_a;
   logic [15:0] mem_a [16];

   assign sdata_a = !oe_n_a ? mem_a[saddr_a[3:0]] : 16'hzzzz;
   always @(posedge clk) if (!we_n_a) mem_a[saddr_a[3:0]] <= sdata_a;

   sram_word_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(WA), .SRAM_AW(18)) dut_a (
      .clk(clk), .rst(rst), .mem_r_en(r_a), .mem_w_en(w_a), .addr(addr_a),
      .wdata(wdata_a), .rdata(rdata_a), .sram_not_ready(nr_a), .sram_addr(saddr_a),
      .sram_we_n(we_n_a), .sram_oe_n(oe_n_a), .sram_data(sdata_a));

   // instance B (W=3), read-only pattern SRAM
   logic        r_b = 1'b0, w_b = 1'b0;
   logic [31:0] addr_b = '0, wdata_b = '0;
   logic [31:0] rdata_b;
   logic        nr_b, we_n_b, oe_n_b;
   logic [17:0] saddr_b;
   wire  [15:0] sdata_b;

   assign sdata_b = !oe_n_b ? (16'hB000 ^ saddr_b[15:0]) : 16'hzzzz;

   sram_word_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(WB), .SRAM_AW(18)) dut_b (
      .clk(clk), .rst(rst), .mem_r_en(r_b), .mem_w_en(w_b), .addr(addr_b),
      .wdata(wdata_b), .rdata(rdata_b), .sram_not_ready(nr_b), .sram_addr(saddr_b),
      .sram_we_n(we_n_b), .sram_oe_n(oe_n_b), .sram_data(sdata_b));

   // views of the instance currently under stimulus
   bit          sel_v = 1'b0;
   wire         nr_v    = sel_v ? nr_b    : nr_a;
   wire         we_v    = sel_v ? we_n_b  : we_n_a;
   wire         oe_v    = sel_v ? oe_n_b  : oe_n_a;
   wire  [17:0] saddr_v = sel_v ? saddr_b : saddr_a;

   pin_t        wrq_a[$], wrq_b[$];
   logic [31:0] rdq_a[$], rdq_b[$];
   logic [15:0] shadow_a [16];
   pin_t        pe_a, pe_b;
   logic [31:0] re_a, re_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pin-level and DONE-time scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (!we_n_a) begin
            if (wrq_a.size() == 0) check("wr_a_unexpected", 32'(we_n_a), 32'd1);
            else begin
               pe_a = wrq_a.pop_front();
               check("wr_a_addr", 32'(saddr_a), 32'(pe_a.a));
               check("wr_a_data", 32'(sdata_a), 32'(pe_a.d));
            end
         end
         if (!we_n_b) begin
            if (wrq_b.size() == 0) check("wr_b_unexpected", 32'(we_n_b), 32'd1);
            else begin
               pe_b = wrq_b.pop_front();
               check("wr_b_addr", 32'(saddr_b), 32'(pe_b.a));
               check("wr_b_data", 32'(sdata_b), 32'(pe_b.d));
            end
         end
         if (r_a && !w_a && !nr_a) begin
            if (rdq_a.size() == 0) check("rd_a_unexpected", 32'(nr_a), 32'd1);
            else begin
               re_a = rdq_a.pop_front();
               check("rdata_a", rdata_a, re_a);
            end
         end
         if (r_b && !w_b && !nr_b) begin
            if (rdq_b.size() == 0) check("rd_b_unexpected", 32'(nr_b), 32'd1);
            else begin
               re_b = rdq_b.pop_front();
               check("rdata_b", rdata_b, re_b);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that leaves DONE.
   task automatic access(input bit sel, input bit wr, input bit rd,
                         input logic [31:0] a, input logic [31:0] d);
      int          w;
      int          n;
      int          we_cnt;
      int          oe_cnt;
      bit          done;
      logic [17:0] base;
      logic [3:0]  i;
      w      = sel ? int'(WB) : int'(WA);
      n      = 0;
      we_cnt = 0;
      oe_cnt = 0;
      done   = 1'b0;
      base   = 18'(((a - 32'd1024) >> 2) << 1);
      i      = base[3:0];
      if (wr) begin
         for (int k = 0; k < w; k++) begin
            if (sel) wrq_b.push_back({base, d[15:0]});
            else     wrq_a.push_back({base, d[15:0]});
         end
         for (int k = 0; k < w; k++) begin
            if (sel) wrq_b.push_back({base + 18'd1, d[31:16]});
            else     wrq_a.push_back({base + 18'd1, d[31:16]});
         end
         if (!sel) begin
            shadow_a[i]        = d[15:0];
            shadow_a[i + 4'd1] = d[31:16];
         end
      end else if (rd) begin
         if (sel) rdq_b.push_back({16'hB000 ^ 16'(base + 18'd1), 16'hB000 ^ 16'(base)});
         else     rdq_a.push_back({shadow_a[i + 4'd1], shadow_a[i]});
      end
      sel_v = sel;
      if (sel) begin r_b = rd; w_b = wr; addr_b = a; wdata_b = d; end
      else     begin r_a = rd; w_a = wr; addr_a = a; wdata_a = d; end
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (!nr_v) done = 1'b1;
         else if (n == 1) begin
            check("idle_oe_n", 32'(oe_v), 32'd1);
            check("idle_we_n", 32'(we_v), 32'd1);
         end else begin
            check("oe_n", 32'(oe_v), (rd && !wr) ? 32'd0 : 32'd1);
            if (!oe_v) check("rd_addr", 32'(saddr_v), 32'(base + 18'((n - 2) / w)));
            if (!we_v) we_cnt++;
            if (!oe_v) oe_cnt++;
         end
      end
      check("done_seen", 32'(done), 32'd1);
      check("stall_cycles", 32'(n - 1), 32'(1 + 2 * w));
      check("we_cycles", 32'(we_cnt), wr ? 32'(2 * w) : 32'd0);
      check("oe_cycles", 32'(oe_cnt), (rd && !wr) ? 32'(2 * w) : 32'd0);
      @(posedge clk);
      #1;
      if (sel) begin r_b = 1'b0; w_b = 1'b0; end
      else     begin r_a = 1'b0; w_a = 1'b0; end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) shadow_a[k] = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", rdata_a, 32'h0);
      check("rst_we_n", 32'(we_n_a), 32'd1);
      check("rst_oe_n", 32'(oe_n_a), 32'd1);
      check("rst_addr", 32'(saddr_a), 32'd0);
      check("rst_not_ready", 32'(nr_a), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // store then load back on the W=1 instance
      access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
      check("mem_lo", 32'(mem_a[0]), 32'h0000BEEF);
      check("mem_hi", 32'(mem_a[1]), 32'h0000DEAD);
      @(posedge clk); #1;
      access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0);
      @(posedge clk); #1;

      // slow halves on the W=3 instance
      access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0);
      @(posedge clk); #1;

      // simultaneous load+store: write wins
      access(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0BADC0DE);

      // back-to-back loads, second issued the cycle after DONE
      @(posedge clk); #1;
      access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0);
      access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0);
      @(posedge clk); #1;

      // reset during the high half of a store
      sel_v = 1'b0;
      wrq_a.push_back({18'd8, 16'hF00D});
      w_a = 1'b1; addr_a = 32'd1040; wdata_a = 32'hCAFEF00D;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("hi_we_n", 32'(we_n_a), 32'd0);
      check("hi_addr", 32'(saddr_a), 32'd9);
      rst = 1'b0;
      #1;
      check("abort_we_n", 32'(we_n_a), 32'd1);
      check("abort_oe_n", 32'(oe_n_a), 32'd1);
      check("abort_addr", 32'(saddr_a), 32'd0);
      w_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 1'b1, 1'b0, 32'd1040, 32'h11112222);
      access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      check("wrq_a_left", 32'(wrq_a.size()), 32'd0);
      check("rdq_a_left", 32'(rdq_a.size()), 32'd0);
      check("rdq_b_left", 32'(rdq_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
